// File: rtl/lane_add_pipe.sv
// Multi-lane two-stage signed adder/accumulator with valid/ready handshakes.
// Define LANE_ADD_SATURATE_EN for saturating arithmetic instead of wrapping.
module lane_add_pipe #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [LANES*WIDTH-1:0] a_i,
    input  logic [LANES*WIDTH-1:0] b_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] res_o,
    output logic [LANES-1:0]       ovf_o,
    output logic [CNT_W-1:0]       txn_cnt
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    logic                         stall;
    logic                         accept;
    logic                         s1_v_q;
    op_e                          s1_op_q;
    logic [LANES*WIDTH-1:0]       s1_a_q;
    logic [LANES*WIDTH-1:0]       s1_b_q;
    logic                         s2_v_q;
    logic [LANES*WIDTH-1:0]       res_q;
    logic [LANES*WIDTH-1:0]       res_d;
    logic [LANES-1:0]             ovf_q;
    logic [LANES-1:0]             ovf_d;
    logic [LANES-1:0][WIDTH-1:0]  acc_q;
    logic [LANES-1:0][WIDTH-1:0]  acc_d;
    logic [CNT_W-1:0]             cnt_q;

    assign stall     = s2_v_q && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v_q;
    assign res_o     = res_q;
    assign ovf_o     = ovf_q;
    assign txn_cnt   = cnt_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] a, b, x, y, s, r, acc_n;
        logic             sub, v;

        assign a = s1_a_q[k*WIDTH +: WIDTH];
        assign b = s1_b_q[k*WIDTH +: WIDTH];

        always_comb begin
            x     = a;
            y     = b;
            sub   = 1'b0;
            acc_n = acc_q[k];
            unique case (s1_op_q)
                OP_ADD: sub = 1'b0;
                OP_SUB: sub = 1'b1;
                OP_ACC: begin
                    x = acc_q[k];
                    y = a;
                end
                OP_CLR: begin
                    x = '0;
                    y = '0;
                end
            endcase
            s = sub ? x - y : x + y;
            // Subtraction overflows when operand signs differ, addition when they match.
            v = ((x[WIDTH-1] ^ y[WIDTH-1]) == sub) && (s[WIDTH-1] != x[WIDTH-1]);
            r = s;
`ifdef LANE_ADD_SATURATE_EN
            if (v)
                r = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            if (s1_op_q == OP_CLR) begin
                r = '0;
                v = 1'b0;
            end
            if (s1_op_q == OP_ACC || s1_op_q == OP_CLR)
                acc_n = r;
        end

        assign res_d[k*WIDTH +: WIDTH] = r;
        assign ovf_d[k]                = v;
        assign acc_d[k]                = acc_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_op_q <= OP_ADD;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s2_v_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept)
                cnt_q <= cnt_q + 1'b1;
            if (!stall) begin
                s1_v_q <= accept;
                if (accept) begin
                    s1_op_q <= op_e'(op);
                    s1_a_q  <= a_i;
                    s1_b_q  <= b_i;
                end
                s2_v_q <= s1_v_q;
                // Accumulators commit as the bundle enters S2, so back-to-back ACCs chain.
                if (s1_v_q) begin
                    res_q <= res_d;
                    ovf_q <= ovf_d;
                    acc_q <= acc_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_add_pipe.sv
// Directed-vector bench for lane_add_pipe (LANES=4, WIDTH=32, CNT_W=4).
module tb_lane_add_pipe;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int CW = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [L*W-1:0] a_i;
    logic [L*W-1:0] b_i;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] res_o;
    logic [L-1:0]   ovf_o;
    logic [CW-1:0]  txn_cnt;

    lane_add_pipe #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a_i(a_i), .b_i(b_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_o(res_o), .ovf_o(ovf_o), .txn_cnt(txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] r;
        logic [L-1:0]   v;
        int             cyc;
    } ent_t;

    ent_t           rq[$];
    int             cyc;
    int             n_cmp;
    int             n_bad;
    bit             bp_on;
    bit             prev_stall;
    logic [L*W-1:0] prev_res;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [L*W-1:0] rep(input logic [W-1:0] v);
        return {L{v}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            rq.push_back('{r: res_o, v: ovf_o, cyc: cyc});
        if (bp_on) begin
            check("bp_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("bp_hold_v", out_valid, 1'b1);
                check("bp_hold_r", res_o, prev_res);
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = res_o;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        a_i       = '0;
        b_i       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rq.delete();
    endtask

    task automatic send(input logic [1:0] o, input logic [L*W-1:0] a,
                        input logic [L*W-1:0] b);
        bit rdy;
        bit done;
        op       = o;
        a_i      = a;
        b_i      = b;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done)
            check("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [L*W-1:0] er,
                             input logic [L-1:0] ev, output int c);
        ent_t e;
        c = 0;
        if (rq.size() == 0) begin
            check({tag, "_missing"}, 1'b0, 1'b1);
        end else begin
            e = rq.pop_front();
            c = e.cyc;
            check({tag, "_res"}, e.r, er);
            check({tag, "_ovf"}, e.v, ev);
        end
    endtask

    logic [L*W-1:0] exp_sub;
    logic [3:0]     pat;
    int             c0, c1, c2, c3;

    initial begin
        cyc        = 0;
        n_cmp      = 0;
        n_bad      = 0;
        bp_on      = 1'b0;
        prev_stall = 1'b0;
        prev_res   = '0;
        pat        = 4'b1001;

        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_res", res_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_cnt", txn_cnt, 0);
        check("rst_ready", in_ready, 1'b1);

        // lane0=10/20, lane1=1/2, lane2=-5/5, lane3=0/0
        send(2'b00, {32'd0, 32'hFFFF_FFFB, 32'd1, 32'd10},
                    {32'd0, 32'd5, 32'd2, 32'd20});
        check("add_lat1", out_valid, 1'b0);
        @(posedge clk); #1;
        check("add_valid", out_valid, 1'b1);
        check("add_res", res_o, {32'd0, 32'd0, 32'd3, 32'd30});
        check("add_ovf", ovf_o, 4'b0000);
        check("add_cnt", txn_cnt, 1);
        @(posedge clk); #1;
        check("add_done", out_valid, 1'b0);
        rq.delete();

`ifdef LANE_ADD_SATURATE_EN
        exp_sub = {96'd0, 32'h7FFF_FFFF};
`else
        exp_sub = {96'd0, 32'h8000_0000};
`endif
        send(2'b01, {96'd0, 32'h7FFF_FFFF}, {96'd0, 32'hFFFF_FFFF});
        repeat (3) @(posedge clk);
        #1;
        pop_check("sub_ovf", exp_sub, 4'b0001, c0);

        send(2'b11, '0, '0);
        send(2'b10, rep(32'd5), rep(32'd99));
        send(2'b10, rep(32'd7), '0);
        send(2'b10, rep(32'hFFFF_FFFE), '0);
        send(2'b00, rep(32'd1), rep(32'd1));
        send(2'b10, rep(32'd0), '0);
        repeat (4) @(posedge clk);
        #1;
        pop_check("acc_clr", '0, 4'b0000, c0);
        pop_check("acc_5", rep(32'd5), 4'b0000, c1);
        pop_check("acc_12", rep(32'd12), 4'b0000, c2);
        pop_check("acc_10", rep(32'd10), 4'b0000, c3);
        check("acc_b2b_a", c2 - c1, 1);
        check("acc_b2b_b", c3 - c2, 1);
        pop_check("acc_add", rep(32'd2), 4'b0000, c0);
        pop_check("acc_keep", rep(32'd10), 4'b0000, c0);

        do_reset();
        bp_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(2'b00, rep(W'(i * 3 + 1)), rep(W'(i * 1000)));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = pat[c % 4];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        bp_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", rq.size(), 6);
        for (int i = 0; i < 6; i++)
            pop_check("bp_item", rep(W'(i * 1003 + 1)), 4'b0000, c0);
        check("bp_cnt", txn_cnt, 6);

        do_reset();
        for (int i = 0; i < 16; i++)
            send(2'b00, rep(W'(i)), '0);
        check("wrap_16", txn_cnt, 0);
        send(2'b00, '0, '0);
        check("wrap_17", txn_cnt, 1);

        do_reset();
        send(2'b10, rep(32'd9), '0);
        send(2'b10, rep(32'd9), '0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rq.delete();
        check("mid_cnt", txn_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_quiet", out_valid, 1'b0);
        check("mid_noemit", rq.size(), 0);
        send(2'b10, rep(32'd3), '0);
        repeat (3) @(posedge clk);
        #1;
        pop_check("mid_acc3", rep(32'd3), 4'b0000, c0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
